vga_text_renderer: RTL and testbench

//  Read side of the debugger's character-buffer write port (wen/w_addr/w_data): owns an 80x30 char RAM,

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/text_font_rom.sv | 22 ++
 rtl/vga_text_renderer.sv | 138 +++++++++++++
 tb/tb_vga_text_renderer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, geometry and font contents for the text-mode renderer.
// Glyph rows are a pure function of (code, row) so the font ROM synthesises as a constant table.
package vga_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int FONT_W     = 8;
  localparam int FONT_H     = 16;

  typedef struct packed {
    logic       video_on;
    logic       hs;
    logic       vs;
    logic [2:0] fx;
    logic [3:0] fy;
  } pix_tag_t;

  typedef enum logic {TR_CLEAR, TR_RUN} text_state_t;

  // Blanked pixel with both syncs at their inactive (high) level
  localparam pix_tag_t TAG_IDLE = '{video_on: 1'b0, hs: 1'b1, vs: 1'b1, fx: 3'd0, fy: 4'd0};

  // row*80 + col, with the multiply split into two shifts
  function automatic logic [11:0] cell_index(input logic [4:0] row, input logic [6:0] col);
    logic [11:0] r12;
    r12 = {7'd0, row};
    return (r12 << 6) + (r12 << 4) + {5'd0, col};
  endfunction

  // Space and 'A' are drawn glyphs; every other code gets a distinct filler pattern
  function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] fy);
    logic [7:0] row;
    row = {fy, code[3:0]} ^ {code, 1'b0};
    if (code == 7'h20) begin
      row = 8'h00;
    end else if (code == 7'h41) begin
      case (fy)
        4'd2:                      row = 8'h10;
        4'd3:                      row = 8'h38;
        4'd4:                      row = 8'h6C;
        4'd7:                      row = 8'hFE;
        4'd5, 4'd6, 4'd8, 4'd9,
        4'd10, 4'd11:              row = 8'hC6;
        default:                   row = 8'h00;
      endcase
    end
    return row;
  endfunction

endpackage

// File: rtl/text_font_rom.sv
// 128 glyphs x 16 rows x 8 px font ROM; one-cycle synchronous read, advancing only when i_ce is high.
// Address is {glyph[6:0], row[3:0]}; output holds while i_ce is low.
module text_font_rom
  import vga_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_ce,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);

  logic [7:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      r_data <= font_row(i_addr[10:4], i_addr[3:0]);
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode renderer: char RAM written by the debugger, pixels out 3 pixel strobes after vga_x/vga_y.
// No backpressure; writes are dropped while the post-reset clear runs (ready low) or when out of range.
module vga_text_renderer
  import vga_pkg::*;
#(
  parameter logic [11:0] FG_RGB     = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [9:0]  vga_x,
  input  logic [8:0]  vga_y,
  input  logic        video_on,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wen,
  input  logic [11:0] w_addr,
  input  logic [7:0]  w_data,
  output logic        ready,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam logic [11:0] LAST_CELL = 12'(TEXT_CELLS - 1);
  localparam logic [11:0] NUM_CELLS = 12'(TEXT_CELLS);

  text_state_t r_state;
  logic [11:0] r_clr_cnt;
  logic        r_ready;

  logic        w_ram_we;
  logic [11:0] w_ram_wa;
  logic [7:0]  w_ram_wd;
  logic [7:0]  r_char_ram [0:4095];
  logic [7:0]  r_char_q;

  logic [11:0] w_cell;
  logic [11:0] r1_cell;
  pix_tag_t    r1_tag;
  pix_tag_t    r2_tag;
  pix_tag_t    r3_tag;
  logic        r3_inv;
  logic [7:0]  w_font_row;
  logic        w_pix_bit;
  logic [11:0] w_rgb;

  // Clear sweeps one cell per clock, independent of the pixel strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TR_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        TR_CLEAR: begin
          if (r_clr_cnt == LAST_CELL) begin
            r_state <= TR_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 12'd1;
          end
        end
        TR_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= TR_CLEAR;
        end
      endcase
    end
  end

  assign ready = r_ready;

  always_comb begin
    w_ram_we = 1'b0;
    w_ram_wa = r_clr_cnt;
    w_ram_wd = CLEAR_CHAR;
    if (r_state == TR_CLEAR) begin
      w_ram_we = 1'b1;
    end else if (wen && (w_addr < NUM_CELLS)) begin
      w_ram_we = 1'b1;
      w_ram_wa = w_addr;
      w_ram_wd = w_data;
    end
  end

  // Nonblocking read and write on the same edge gives read-first behaviour
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_char_ram[w_ram_wa] <= w_ram_wd;
    end
    if (pix_ce) begin
      r_char_q <= r_char_ram[r1_cell];
    end
  end

  assign w_cell = cell_index(vga_y[8:4], vga_x[9:3]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_cell <= '0;
      r1_tag  <= TAG_IDLE;
      r2_tag  <= TAG_IDLE;
      r3_tag  <= TAG_IDLE;
      r3_inv  <= 1'b0;
    end else if (pix_ce) begin
      r1_cell <= w_cell;
      r1_tag  <= '{video_on: video_on, hs: hs_in, vs: vs_in, fx: vga_x[2:0], fy: vga_y[3:0]};
      r2_tag  <= r1_tag;
      r3_tag  <= r2_tag;
      r3_inv  <= r_char_q[7];
    end
  end

  text_font_rom u_font (
    .i_clk  (clk),
    .i_ce   (pix_ce),
    .i_addr ({r_char_q[6:0], r2_tag.fy}),
    .o_data (w_font_row)
  );

  // Leftmost pixel of a glyph row is bit 7
  assign w_pix_bit = w_font_row[3'd7 - r3_tag.fx] ^ r3_inv;
  assign w_rgb     = r3_tag.video_on ? (w_pix_bit ? FG_RGB : BG_RGB) : 12'h000;

  assign vga_r = w_rgb[11:8];
  assign vga_g = w_rgb[7:4];
  assign vga_b = w_rgb[3:0];
  assign hs    = r3_tag.hs;
  assign vs    = r3_tag.vs;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed + randomized bench for vga_text_renderer against a screen-level reference model.
module tb_vga_text_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        video_on;
  logic        hs_in;
  logic        vs_in;
  logic        wen;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic        ready;
  logic        hs;
  logic        vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference screen contents and a latency model: capture, char lookup, visible
  logic [7:0]  m_ram [0:2399];
  bit          m_run;
  int          m1_x, m1_y, m1_von, m1_hs, m1_vs;
  logic [13:0] m2_exp;
  logic [13:0] m_out;

  vga_text_renderer dut (
    .clk      (clk),
    .rst      (rst),
    .pix_ce   (pix_ce),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .video_on (video_on),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .wen      (wen),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .ready    (ready),
    .hs       (hs),
    .vs       (vs),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph_row(input logic [7:0] ch, input int fy);
    int c;
    c = int'(ch[6:0]);
    if (c == 'h20) return 8'h00;
    if (c == 'h41) begin
      case (fy)
        2:                    return 8'h10;
        3:                    return 8'h38;
        4:                    return 8'h6C;
        7:                    return 8'hFE;
        5, 6, 8, 9, 10, 11:   return 8'hC6;
        default:              return 8'h00;
      endcase
    end
    return 8'(((fy * 16) + (c % 16)) ^ ((c * 2) % 256));
  endfunction

  function automatic logic [13:0] resolve(input int x, input int y, input int von, input int hsi, input int vsi);
    logic [7:0] ch;
    logic [7:0] row;
    logic       b;
    logic       h;
    logic       v;
    h = (hsi != 0);
    v = (vsi != 0);
    if (von == 0) return {h, v, 12'h000};
    ch  = m_ram[(y / 16) * 80 + (x / 8)];
    row = glyph_row(ch, y % 16);
    b   = row[7 - (x % 8)] ^ ch[7];
    return {h, v, (b ? FG : BG)};
  endfunction

  task automatic model_reset();
    m1_x = 0; m1_y = 0; m1_von = 0; m1_hs = 1; m1_vs = 1;
    m2_exp = {2'b11, 12'h000};
    m_out  = {2'b11, 12'h000};
    m_run  = 1'b0;
  endtask

  task automatic pix_step(input int ce, input int x, input int y, input int von, input int hsi,
                          input int vsi, input int we, input int wa, input int wd);
    pix_ce   = (ce != 0);
    vga_x    = x[9:0];
    vga_y    = y[8:0];
    video_on = (von != 0);
    hs_in    = (hsi != 0);
    vs_in    = (vsi != 0);
    wen      = (we != 0);
    w_addr   = wa[11:0];
    w_data   = wd[7:0];
    @(posedge clk);
    if (ce != 0) begin
      m_out  = m2_exp;
      m2_exp = resolve(m1_x, m1_y, m1_von, m1_hs, m1_vs);
      m1_x = x; m1_y = y; m1_von = von; m1_hs = hsi; m1_vs = vsi;
    end
    if (we != 0 && m_run && wa < 2400) m_ram[wa] = wd[7:0];
    #1;
    pix_ce = 1'b0;
    wen    = 1'b0;
    check("pix", {18'd0, hs, vs, vga_r, vga_g, vga_b}, {18'd0, m_out});
  endtask

  task automatic write_cell(input int wa, input int wd);
    pix_step(0, 0, 0, 0, 1, 1, 1, wa, wd);
  endtask

  task automatic flush();
    repeat (3) pix_step(1, 0, 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_hs"}, 32'(hs), 32'd1);
    check({tag, "_vs"}, 32'(vs), 32'd1);
    check({tag, "_rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
  endtask

  task automatic run_clear(input bit poke);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      if (poke && n == 100) begin
        wen = 1'b1; w_addr = 12'd5; w_data = 8'h41;
      end else begin
        wen = 1'b0;
      end
    end
    wen = 1'b0;
    check("clear_len", n, 32'd2400);
    for (int i = 0; i < 2400; i++) m_ram[i] = 8'h20;
    m_run = 1'b1;
  endtask

  task automatic dump_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (dut.r_char_ram[i] !== m_ram[i]) bad++;
    end
    check(tag, bad, 32'd0);
  endtask

  initial begin
    rst = 1'b0; pix_ce = 1'b0; vga_x = '0; vga_y = '0; video_on = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; wen = 1'b0; w_addr = '0; w_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b1;

    // Clear length, with a write attempt mid-clear that must be ignored
    run_clear(1'b1);
    dump_check("clear_dump");
    check("cell5_after_clear", 32'(dut.r_char_ram[5]), 32'h20);

    // Glyph 'A' in cell 0, then its inverse; 3 idle clocks between strobes check hold
    for (int pass = 0; pass < 2; pass++) begin
      write_cell(0, (pass == 0) ? 'h41 : 'hC1);
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 8; x++) begin
          pix_step(1, x, y, 1, 1, 1, 0, 0, 0);
          repeat (3) pix_step(0, 7 - x, 15 - y, 0, 0, 0, 0, 0, 0);
        end
      end
      flush();
    end

    // Sync delay in blanking
    for (int i = 0; i < 64; i++) begin
      pix_step((i % 3 != 2) ? 1 : 0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0,
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 0, 0);
    end
    flush();

    // Out-of-range writes are dropped
    write_cell(2400, 'h41);
    write_cell(4000, 'h41);
    check("oob_2400", 32'(dut.r_char_ram[2400] == 8'h41), 32'd0);
    check("oob_4000", 32'(dut.r_char_ram[4000] == 8'h41), 32'd0);
    dump_check("oob_dump");

    // Last cell, bottom-right corner of the screen
    write_cell(2399, 'h41);
    for (int y = 464; y < 480; y++) begin
      for (int x = 632; x < 640; x++) pix_step(1, x, y, 1, 0, 1, 0, 0, 0);
    end
    flush();

    // Random writes and pixels concentrated on the top-left 10x3 cells
    for (int i = 0; i < 1500; i++) begin
      int r, wa;
      r  = int'($urandom_range(0, 9));
      wa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2) * 80 + $urandom_range(0, 9))
                                       : int'($urandom_range(0, 4095));
      pix_step((r < 4) ? 1 : 0, int'($urandom_range(0, 79)), int'($urandom_range(0, 47)),
               ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), (r >= 6) ? 1 : 0, wa, int'($urandom_range(0, 255)));
    end
    flush();
    dump_check("rand_dump");
    check("ready_run", 32'(ready), 32'd1);

    // Read-first: write to cell 81 on the same edge that reads it
    write_cell(81, 'h41);
    flush();
    pix_step(1, 8, 21, 1, 0, 0, 0, 0, 0);
    pix_step(1, 9, 21, 1, 0, 0, 1, 81, 'hC1);
    pix_step(1, 8, 21, 1, 0, 0, 0, 0, 0);
    flush();

    // Asynchronous reset mid-frame while a foreground row of 'A' is on screen
    write_cell(0, 'h41);
    for (int x = 0; x < 8; x++) pix_step(1, x, 7, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_clear(1'b0);
    dump_check("reclear_dump");
    for (int x = 0; x < 8; x++) pix_step(1, x, 7, 1, 1, 1, 0, 0, 0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
